// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register and its users.
package usr_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;
endpackage

// File: rtl/usr_sat_cnt.sv
// Saturating up-counter: sync clear beats increment, holds once it reaches MAX.
module usr_sat_cnt #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  assign sat = (cnt == W'(MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && !sat) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: load, shift, rotate, arithmetic shift, clear, with serial
// taps and a saturating shift counter for serialiser/deserialiser use.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shcnt,
  output logic             done
);
  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v, asr_v, nxt;
  logic             cnt_clr, cnt_inc;

  assign sout_msb = out[WIDTH-1];
  assign sout_lsb = out[0];

  // A 1-bit register has no neighbours: shifts take the serial input, the rest are no-ops.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_v = sin_l;
      assign shr_v = sin_r;
      assign rol_v = out;
      assign ror_v = out;
      assign asr_v = out;
    end else begin : g_wn
      assign shl_v = {out[WIDTH-2:0], sin_l};
      assign shr_v = {sin_r, out[WIDTH-1:1]};
      assign rol_v = {out[WIDTH-2:0], out[WIDTH-1]};
      assign ror_v = {out[0], out[WIDTH-1:1]};
      assign asr_v = {out[WIDTH-1], out[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    nxt     = out;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: nxt = out;
        MODE_LOAD: begin nxt = pin;       cnt_clr = 1'b1; end
        MODE_SHL:  begin nxt = shl_v;     cnt_inc = 1'b1; end
        MODE_SHR:  begin nxt = shr_v;     cnt_inc = 1'b1; end
        MODE_ROL:  begin nxt = rol_v;     cnt_inc = 1'b1; end
        MODE_ROR:  begin nxt = ror_v;     cnt_inc = 1'b1; end
        MODE_ASR:  begin nxt = asr_v;     cnt_inc = 1'b1; end
        MODE_CLR:  begin nxt = RESET_VAL; cnt_clr = 1'b1; end
        default:   nxt = out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out <= RESET_VAL;
    else        out <= nxt;
  end

  usr_sat_cnt #(.MAX(WIDTH), .W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (shcnt),
    .sat   (done)
  );
endmodule
